// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - boot phase codes and loader state codes
package boot_pkg;

    typedef enum logic [1:0] {
        BS_OFF    = 2'b00,
        BS_FIRST  = 2'b01,
        BS_SECOND = 2'b10,
        BS_NORMAL = 2'b11
    } boot_state_e;

    typedef enum logic [2:0] {
        L_IDLE  = 3'd0,
        L_READ  = 3'd1,
        L_CAPT  = 3'd2,
        L_WRITE = 3'd3,
        L_DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - copies boot ROM into IMEM and stalls the core until done
module boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        boot_state,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic              imem_ack,
    output logic              cpu_stall,
    output logic              boot_done,
    output logic [DATA_W-1:0] checksum
);
    import boot_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] checksum_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [DATA_W-1:0] imem_wdata_q;
    logic              capture;
    logic              accept;
    logic              abort;

    // Next-state and strobe decode; OFF outside idle overrides every transition
    always_comb begin
        state_d = state_q;
        rom_rd  = 1'b0;
        imem_we = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            L_IDLE: begin
                if (boot_state == BS_FIRST) state_d = L_READ;
            end
            L_READ: begin
                rom_rd  = 1'b1;
                state_d = L_CAPT;
            end
            L_CAPT: begin
                capture = 1'b1;
                state_d = L_WRITE;
            end
            L_WRITE: begin
                imem_we = 1'b1;
                if (imem_ack) begin
                    accept  = 1'b1;
                    state_d = (idx_q == LAST_IDX) ? L_DONE : L_READ;
                end
            end
            L_DONE: begin
                state_d = L_DONE;
            end
            default: state_d = L_IDLE;
        endcase
        if (state_q != L_IDLE && boot_state == BS_OFF) begin
            abort   = 1'b1;
            capture = 1'b0;
            accept  = 1'b0;
            state_d = L_IDLE;
        end
    end

    // State, word index, checksum and the held IMEM write beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= L_IDLE;
            idx_q        <= '0;
            checksum_q   <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                idx_q      <= '0;
                checksum_q <= '0;
            end else begin
                if (capture) begin
                    imem_addr_q  <= idx_q;
                    imem_wdata_q <= rom_data;
                end
                if (accept) begin
                    checksum_q <= checksum_q + imem_wdata_q;
                    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign rom_addr   = idx_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign checksum   = checksum_q;
    assign boot_done  = (state_q == L_DONE);
    assign cpu_stall  = !((state_q == L_DONE) && (boot_state == BS_NORMAL));

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - randomized directed bench for boot_loader with reference model
module tb_boot_loader;
    import boot_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  boot_state;
    logic        tie1;
    assign tie1 = 1'b1;

    logic        rd4, we4, stall4, done4, ack4;
    logic [7:0]  addr4, iaddr4;
    logic [31:0] rdata4, wdata4, csum4;
    logic        rd2, we2, stall2, done2;
    logic [7:0]  addr2, iaddr2;
    logic [31:0] rdata2, wdata2, csum2;
    logic        rd1, we1, stall1, done1;
    logic [7:0]  addr1, iaddr1;
    logic [31:0] rdata1, wdata1, csum1;

    logic [31:0] rom4 [256];
    logic [31:0] rom2 [256];
    logic [31:0] rom1 [256];
    logic [39:0] wq4 [$];
    logic [39:0] wq1 [$];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .boot_state(boot_state),
        .rom_rd(rd4), .rom_addr(addr4), .rom_data(rdata4),
        .imem_we(we4), .imem_addr(iaddr4), .imem_wdata(wdata4), .imem_ack(ack4),
        .cpu_stall(stall4), .boot_done(done4), .checksum(csum4));

    boot_loader #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(2)) dut2 (
        .clk(clk), .rst(rst), .boot_state(boot_state),
        .rom_rd(rd2), .rom_addr(addr2), .rom_data(rdata2),
        .imem_we(we2), .imem_addr(iaddr2), .imem_wdata(wdata2), .imem_ack(tie1),
        .cpu_stall(stall2), .boot_done(done2), .checksum(csum2));

    boot_loader #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .boot_state(boot_state),
        .rom_rd(rd1), .rom_addr(addr1), .rom_data(rdata1),
        .imem_we(we1), .imem_addr(iaddr1), .imem_wdata(wdata1), .imem_ack(tie1),
        .cpu_stall(stall1), .boot_done(done1), .checksum(csum1));

    // ROM models: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rd4) rdata4 <= rom4[addr4];
        if (rd2) rdata2 <= rom2[addr2];
        if (rd1) rdata1 <= rom1[addr1];
    end

    // IMEM models: log every accepted write beat
    always @(posedge clk) begin
        if (!rst && we4 && ack4) wq4.push_back({iaddr4, wdata4});
        if (!rst && we1) wq1.push_back({iaddr1, wdata1});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_sum(input int n);
        logic [31:0] s = 32'h0;
        for (int i = 0; i < n; i++) s = s + rom4[i];
        return s;
    endfunction

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(wq4.size()), 64'd4);
        for (int i = 0; i < 4 && i < wq4.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(wq4[i]), 64'({8'(i), rom4[i]}));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_rd"}, 64'(rd4), 64'd0);
        check({tag, "_imem_we"}, 64'(we4), 64'd0);
        check({tag, "_rom_addr"}, 64'(addr4), 64'd0);
        check({tag, "_imem_addr"}, 64'(iaddr4), 64'd0);
        check({tag, "_imem_wdata"}, 64'(wdata4), 64'd0);
        check({tag, "_cpu_stall"}, 64'(stall4), 64'd1);
        check({tag, "_boot_done"}, 64'(done4), 64'd0);
        check({tag, "_checksum"}, 64'(csum4), 64'd0);
    endtask

    // Waits (bounded) for the first read strobe of a copy
    task automatic wait_rd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd4 && n < 10);
        check("wait_rom_rd", 64'(rd4), 64'd1);
    endtask

    // Runs one copy from the first L_READ cycle; mode 0 ack high, 1 random ack, 2 ack low on word 2 for 5 cycles
    task automatic run_copy(input int mode, output int k, output int stalls, output int t2, output int t1);
        k = 0; stalls = 0; t2 = -1; t1 = -1;
        while (!done4 && k < 400) begin
            @(negedge clk);
            k++;
            if (mode == 1)      ack4 = ($urandom_range(0, 3) != 0);
            else if (mode == 2) ack4 = !(k >= 8 && k <= 12);
            else                ack4 = 1'b1;
            if (we4 && !ack4) stalls++;
            if (k == 1) boot_state = BS_SECOND;
            if (k == 4) boot_state = BS_NORMAL;
            if (k == 6) check("stall_during_copy", 64'(stall4), 64'd1);
            if (mode == 2 && (k == 9 || k == 13)) begin
                check("bp_we", 64'(we4), 64'd1);
                check("bp_addr", 64'(iaddr4), 64'd2);
                check("bp_wdata", 64'(wdata4), 64'(rom4[2]));
                check("bp_idx", 64'(addr4), 64'd2);
            end
            if (done2 && t2 < 0) t2 = k;
            if (done1 && t1 < 0) t1 = k;
        end
        ack4 = 1'b1;
        check("copy_finished", 64'(done4), 64'd1);
    endtask

    task automatic abort_now();
        @(negedge clk);
        boot_state = BS_OFF;
        @(negedge clk);
        check("abort_done", 64'(done4), 64'd0);
        check("abort_csum", 64'(csum4), 64'd0);
        check("abort_we", 64'(we4), 64'd0);
    endtask

    initial begin
        int k, st, t2, t1, seen;
        rst = 1'b1;
        boot_state = BS_OFF;
        ack4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rom4[i] = 32'h0; rom2[i] = 32'h0; rom1[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Nominal copy, with wrap on the 2-word loader and a 1-word loader alongside
        for (int i = 0; i < 4; i++) rom4[i] = 32'h1000_0000 + 32'(i);
        rom2[0] = 32'hFFFF_FFFF;
        rom2[1] = 32'h0000_0002;
        rom1[0] = $urandom;
        @(negedge clk);
        wq4.delete(); wq1.delete();
        boot_state = BS_FIRST;
        wait_rd();
        check("nom_first_addr", 64'(addr4), 64'd0);
        run_copy(0, k, st, t2, t1);
        check("nom_cycles", 64'(k), 64'd12);
        check("nom_csum_const", 64'(csum4), 64'h4000_0006);
        check("nom_csum_model", 64'(csum4), 64'(model_sum(4)));
        check("nom_stall_released", 64'(stall4), 64'd0);
        check_writes("nom");
        check("wrap_cycles", 64'(t2), 64'd6);
        check("wrap_csum", 64'(csum2), 64'h0000_0001);
        check("min_cycles", 64'(t1), 64'd3);
        check("min_csum", 64'(csum1), 64'(rom1[0]));
        check("min_writes", 64'(wq1.size()), 64'd1);
        if (wq1.size() > 0) check("min_write0", 64'(wq1[0]), 64'({8'd0, rom1[0]}));

        // Back-pressure on word 2
        abort_now();
        for (int i = 0; i < 4; i++) rom4[i] = $urandom;
        wq4.delete();
        boot_state = BS_FIRST;
        wait_rd();
        run_copy(2, k, st, t2, t1);
        check("bp_stalls", 64'(st), 64'd5);
        check("bp_cycles", 64'(k), 64'd17);
        check("bp_csum", 64'(csum4), 64'(model_sum(4)));
        check_writes("bp");

        // Abort during the write of word 1, then restart
        abort_now();
        for (int i = 0; i < 4; i++) rom4[i] = $urandom | 32'h1;
        boot_state = BS_FIRST;
        wait_rd();
        repeat (5) @(negedge clk);
        check("ab_pre_we", 64'(we4), 64'd1);
        check("ab_pre_addr", 64'(iaddr4), 64'd1);
        check("ab_pre_csum", 64'(csum4), 64'(rom4[0]));
        boot_state = BS_OFF;
        @(negedge clk);
        check("ab_we", 64'(we4), 64'd0);
        check("ab_csum", 64'(csum4), 64'd0);
        check("ab_done", 64'(done4), 64'd0);
        wq4.delete();
        boot_state = BS_FIRST;
        wait_rd();
        check("ab_restart_addr", 64'(addr4), 64'd0);
        run_copy(0, k, st, t2, t1);
        check("ab_cycles", 64'(k), 64'd12);
        check("ab_csum_final", 64'(csum4), 64'(model_sum(4)));
        check_writes("ab");

        // Random data with random acknowledge timing
        for (int r = 0; r < 4; r++) begin
            abort_now();
            for (int i = 0; i < 4; i++) rom4[i] = $urandom;
            wq4.delete();
            boot_state = BS_FIRST;
            wait_rd();
            run_copy(1, k, st, t2, t1);
            check($sformatf("rnd%0d_cycles", r), 64'(k), 64'(12 + st));
            check($sformatf("rnd%0d_csum", r), 64'(csum4), 64'(model_sum(4)));
            check_writes($sformatf("rnd%0d", r));
        end

        // Reset during L_CAPT, phase left at NORMAL afterwards
        abort_now();
        boot_state = BS_FIRST;
        wait_rd();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        boot_state = BS_NORMAL;
        check_reset_values("mid_rst");
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd4 || we4 || done4 || !stall4) seen++;
        end
        check("post_rst_idle", 64'(seen), 64'd0);
        check("post_rst_stall", 64'(stall4), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
